// File: rtl/result_dump_pkg.sv
// Shared types and constants for the result dump streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_dump_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        CNT     = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        WORD    = 3'd5,
        TRAIL   = 3'd6,
        FIN     = 3'd7
    } state_t;

    // Framing bytes around each dump.
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRL_BYTE = 8'h5A;

    // clock_count and instr_count, 4 bytes each.
    localparam int CNT_BYTES = 8;

    // Bytes on the stream for one dump: header, two counters, words, trailer.
    function automatic int unsigned dump_bytes(input int unsigned num_words,
                                               input int unsigned reg_width);
        return 32'd10 + num_words * (reg_width / 32'd8);
    endfunction

endpackage

// File: rtl/result_dump_if.sv
// Memory read port and byte stream grouped for the result dump block.
// Latency: n/a (wiring only).
// Backpressure: tx_ready from the sink stalls the byte stream.
interface result_dump_if #(
    parameter int REG_WIDTH = 32
) ();
    logic                 mem_rd_en;
    logic [31:0]          mem_index;
    logic [REG_WIDTH-1:0] mem_data;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Dump block side: issues memory reads, sources the byte stream.
    modport master (
        output mem_rd_en,
        output mem_index,
        input  mem_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Memory/sink side.
    modport slave (
        input  mem_rd_en,
        input  mem_index,
        output mem_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/byte_serializer.sv
// Loads up to W bits and streams them out one byte at a time, LSB byte first.
// Latency: first byte is valid the cycle after load; one byte per accepted cycle.
// Backpressure: tx_data/tx_valid hold while tx_ready is low.
module byte_serializer #(
    parameter int W  = 64,
    parameter int CW = $clog2(W / 8 + 1)
) (
    input  logic          CLOCK_50,
    input  logic          rstn,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_bytes,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic          last
);

    logic [W-1:0]  shreg;
    logic [CW-1:0] remaining;
    logic          fire;

    assign tx_valid = (remaining != '0);
    assign tx_data  = shreg[7:0];
    assign fire     = tx_valid && tx_ready;
    // Final byte of the loaded word is being accepted this cycle.
    assign last     = fire && (remaining == CW'(1));

    // Shift register and remaining-byte count; a load takes priority over a shift.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            shreg     <= load_data;
            remaining <= load_bytes;
        end else if (fire) begin
            shreg     <= {8'h00, shreg[W-1:8]};
            remaining <= remaining - CW'(1);
        end
    end

endmodule

// File: rtl/result_dump.sv
// Streams a CPU result dump: A5, cycle/instr counts, NUM_WORDS memory words, 5A.
// Latency: header valid the cycle after done; 2 idle cycles per word for the memory read.
// Backpressure: tx_ready low stalls the stream with tx_data held; no bytes dropped.
module result_dump
    import result_dump_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int BASE_WORD = 200,
    parameter int NUM_WORDS = 100
) (
    input  logic          CLOCK_50,
    input  logic          rstn,
    input  logic          done,
    input  logic [31:0]   clock_count,
    input  logic [31:0]   instr_count,
    result_dump_if.master bus,
    output logic          dump_busy,
    output logic          dump_done
);

    // Serializer must hold both counters at once as well as one memory word.
    localparam int SER_W = (REG_WIDTH > 64) ? REG_WIDTH : 64;
    localparam int BCW   = $clog2(SER_W / 8 + 1);

    // Word counter covers 0..NUM_WORDS-1 and stops at the last index.
    localparam int               WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int               LAST_WORD = (NUM_WORDS > 0) ? NUM_WORDS - 1 : 0;
    localparam logic [WCW-1:0]   LAST_IDX  = WCW'(LAST_WORD);
    localparam bit               NO_WORDS  = (NUM_WORDS == 0);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      clk_cap;
    logic [31:0]      instr_cap;
    logic [WCW-1:0]   word_cnt;
    logic             last_word;

    logic             ser_load;
    logic [SER_W-1:0] ser_data;
    logic [BCW-1:0]   ser_bytes;
    logic             ser_last;

    assign last_word = (word_cnt == LAST_IDX);

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: each streaming state advances when its last byte is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done)     state_nxt = HDR;
            HDR:     if (ser_last) state_nxt = CNT;
            CNT:     if (ser_last) state_nxt = NO_WORDS ? TRAIL : RD_REQ;
            RD_REQ:                state_nxt = RD_WAIT;
            RD_WAIT:               state_nxt = WORD;
            WORD:    if (ser_last) state_nxt = last_word ? TRAIL : RD_REQ;
            TRAIL:   if (ser_last) state_nxt = FIN;
            FIN:     if (!done)    state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Outputs: memory strobe, status flags, and serializer loads on state entry.
    always_comb begin
        bus.mem_rd_en = 1'b0;
        bus.mem_index = '0;
        dump_busy     = (state != IDLE) && (state != FIN);
        dump_done     = (state == FIN);
        ser_load      = 1'b0;
        ser_data      = '0;
        ser_bytes     = '0;
        case (state)
            IDLE: begin
                if (done) begin
                    ser_load  = 1'b1;
                    ser_data  = SER_W'(HDR_BYTE);
                    ser_bytes = BCW'(1);
                end
            end
            HDR: begin
                if (ser_last) begin
                    ser_load  = 1'b1;
                    ser_data  = SER_W'({instr_cap, clk_cap});
                    ser_bytes = BCW'(CNT_BYTES);
                end
            end
            CNT: begin
                if (ser_last && NO_WORDS) begin
                    ser_load  = 1'b1;
                    ser_data  = SER_W'(TRL_BYTE);
                    ser_bytes = BCW'(1);
                end
            end
            RD_REQ: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_index = 32'(BASE_WORD) + 32'(word_cnt);
            end
            RD_WAIT: begin
                ser_load  = 1'b1;
                ser_data  = SER_W'(bus.mem_data);
                ser_bytes = BCW'(REG_WIDTH / 8);
            end
            WORD: begin
                if (ser_last && last_word) begin
                    ser_load  = 1'b1;
                    ser_data  = SER_W'(TRL_BYTE);
                    ser_bytes = BCW'(1);
                end
            end
            default: ;
        endcase
    end

    // Counter snapshot at trigger time and word index; later input changes are ignored.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            clk_cap   <= '0;
            instr_cap <= '0;
            word_cnt  <= '0;
        end else if (state == IDLE && done) begin
            clk_cap   <= clock_count;
            instr_cap <= instr_count;
            word_cnt  <= '0;
        end else if (state == WORD && ser_last && !last_word) begin
            word_cnt  <= word_cnt + WCW'(1);
        end
    end

    byte_serializer #(
        .W  (SER_W),
        .CW (BCW)
    ) u_ser (
        .CLOCK_50   (CLOCK_50),
        .rstn       (rstn),
        .load       (ser_load),
        .load_data  (ser_data),
        .load_bytes (ser_bytes),
        .tx_ready   (bus.tx_ready),
        .tx_data    (bus.tx_data),
        .tx_valid   (bus.tx_valid),
        .last       (ser_last)
    );

endmodule

// File: tb/tb_result_dump.sv
// Bench for result_dump: a four-word instance (BASE_WORD=8) and a zero-word instance.
// Table of dump scenarios plus hand-written reset and done-held sequences.
module tb_result_dump;
    import result_dump_pkg::*;

    typedef struct {
        bit          sel;       // 0: four-word instance, 1: zero-word instance
        int          mode;      // tx_ready pattern: 0 always high, 1 toggle, 2 random
        logic [31:0] cc;
        logic [31:0] ic;
        bit          lit;       // expect the hand-written 26-byte stream
        int          exp_len;
        int          exp_reads;
    } vec_t;

    localparam int NV = 5;

    logic        CLOCK_50 = 1'b0;
    logic        rstn;
    logic        done;
    logic [31:0] clock_count;
    logic [31:0] instr_count;
    logic        busy4, ddone4, busy0, ddone0;
    logic        ready;

    int          checks = 0;
    int          errors = 0;
    bit          sel;
    int          rdy_mode;
    bit          collect;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic [7:0]  got_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] mem [0:15];
    vec_t        vecs [NV];

    logic [7:0] lit26 [26] = '{8'hA5, 8'h64, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
                               8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                               8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'h5A};

    always #10 CLOCK_50 = ~CLOCK_50;

    result_dump_if #(.REG_WIDTH(32)) bus4 ();
    result_dump_if #(.REG_WIDTH(32)) bus0 ();

    assign bus4.tx_ready = ready;
    assign bus0.tx_ready = ready;
    assign bus0.mem_data = 32'h0;

    result_dump #(.REG_WIDTH(32), .BASE_WORD(8), .NUM_WORDS(4)) dut4 (
        .CLOCK_50(CLOCK_50), .rstn(rstn), .done(done), .clock_count(clock_count),
        .instr_count(instr_count), .bus(bus4), .dump_busy(busy4), .dump_done(ddone4));

    result_dump #(.REG_WIDTH(32), .BASE_WORD(8), .NUM_WORDS(0)) dut0 (
        .CLOCK_50(CLOCK_50), .rstn(rstn), .done(done), .clock_count(clock_count),
        .instr_count(instr_count), .bus(bus0), .dump_busy(busy0), .dump_done(ddone0));

    // Data memory: one-cycle read latency.
    always @(posedge CLOCK_50) begin
        if (bus4.mem_rd_en) bus4.mem_data <= mem[bus4.mem_index[3:0]];
    end

    // tx_ready pattern, changed just after each rising edge.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge CLOCK_50);
            #1;
            case (rdy_mode)
                1:       ready = ~ready;
                2:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Byte/read monitor on the selected instance, sampled on the falling edge.
    initial begin
        logic       v, r;
        logic [7:0] d;
        prev_stall = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            v = sel ? bus0.tx_valid : bus4.tx_valid;
            d = sel ? bus0.tx_data  : bus4.tx_data;
            r = ready;
            if (collect) begin
                if (prev_stall) begin
                    checks++;
                    if (!v || d !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                                 v, d, prev_data);
                    end
                end
                if (v && r) got_q.push_back(d);
                prev_stall = v && !r;
                prev_data  = d;
                if (!sel && bus4.mem_rd_en) rd_q.push_back(bus4.mem_index);
                if (sel && bus0.mem_rd_en)  rd_q.push_back(bus0.mem_index);
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic build_exp(input bit use_lit, input bit s, input logic [31:0] cc,
                             input logic [31:0] ic);
        exp_q.delete();
        if (use_lit) begin
            for (int i = 0; i < 26; i++) exp_q.push_back(lit26[i]);
        end else begin
            exp_q.push_back(8'hA5);
            for (int b = 0; b < 4; b++) exp_q.push_back(cc[8*b +: 8]);
            for (int b = 0; b < 4; b++) exp_q.push_back(ic[8*b +: 8]);
            if (!s) begin
                for (int w = 8; w < 12; w++)
                    for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
            end
            exp_q.push_back(8'h5A);
        end
    endtask

    task automatic compare_stream(input string name, input int exp_len);
        check({name, "_len"}, got_q.size(), exp_len);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    // Waits until both instances are back in IDLE with dump_done low.
    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge CLOCK_50);
            ok = !busy4 && !busy0 && !ddone4 && !ddone0;
        end
        check({name, "_idle"}, ok, 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit seen = 1'b0;
        sel = v.sel;
        rdy_mode = v.mode;
        clock_count = v.cc;
        instr_count = v.ic;
        got_q.delete();
        rd_q.delete();
        @(posedge CLOCK_50);
        #1;
        collect = 1'b1;
        done = 1'b1;
        @(posedge CLOCK_50);
        #1;
        done = 1'b0;
        clock_count = ~v.cc;
        instr_count = v.ic ^ 32'hFFFF0000;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge CLOCK_50);
            if (n == 2) done = 1'b1;
            if (n == 3) done = 1'b0;
            seen = sel ? ddone0 : ddone4;
        end
        check({name, "_dump_done"}, seen, 1);
        check({name, "_busy_fin"}, sel ? busy0 : busy4, 0);
        wait_idle(name);
        collect = 1'b0;
        rdy_mode = 0;
        build_exp(v.lit, v.sel, v.cc, v.ic);
        compare_stream(name, v.exp_len);
        check({name, "_reads"}, rd_q.size(), v.exp_reads);
        for (int i = 0; i < rd_q.size() && i < v.exp_reads; i++)
            check($sformatf("%s_rd_index%0d", name, i), rd_q[i], 8 + i);
    endtask

    initial begin
        rstn = 1'b0;
        done = 1'b0;
        clock_count = '0;
        instr_count = '0;
        sel = 1'b0;
        rdy_mode = 0;
        collect = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0F0F0000 + i;
        mem[8]  = 32'h11223344;
        mem[9]  = 32'h55667788;
        mem[10] = 32'h99AABBCC;
        mem[11] = 32'hDDEEFF00;

        vecs[0] = '{sel: 1'b0, mode: 0, cc: 32'h64, ic: 32'h20, lit: 1'b1, exp_len: 26, exp_reads: 4};
        vecs[1] = '{sel: 1'b0, mode: 1, cc: 32'h64, ic: 32'h20, lit: 1'b1, exp_len: 26, exp_reads: 4};
        vecs[2] = '{sel: 1'b0, mode: 2, cc: 32'hDEADBEEF, ic: 32'h01020304, lit: 1'b0, exp_len: 26, exp_reads: 4};
        vecs[3] = '{sel: 1'b1, mode: 0, cc: 32'h64, ic: 32'h20, lit: 1'b0, exp_len: 10, exp_reads: 0};
        vecs[4] = '{sel: 1'b1, mode: 1, cc: 32'hCAFEF00D, ic: 32'h12345678, lit: 1'b0, exp_len: 10, exp_reads: 0};

        // Reset state.
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_tx_valid", bus4.tx_valid, 0);
        check("rst_tx_data", bus4.tx_data, 0);
        check("rst_mem_rd_en", bus4.mem_rd_en, 0);
        check("rst_mem_index", bus4.mem_index, 0);
        check("rst_busy", busy4, 0);
        check("rst_dump_done", ddone4, 0);
        check("rst0_tx_valid", bus0.tx_valid, 0);
        @(posedge CLOCK_50);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset after the 12th byte, then a full dump from the header.
        begin
            bit reached = 1'b0;
            sel = 1'b0;
            rdy_mode = 0;
            clock_count = 32'h64;
            instr_count = 32'h20;
            got_q.delete();
            rd_q.delete();
            @(posedge CLOCK_50);
            #1;
            collect = 1'b1;
            done = 1'b1;
            @(posedge CLOCK_50);
            #1;
            done = 1'b0;
            for (int n = 0; n < 2000 && !reached; n++) begin
                @(negedge CLOCK_50);
                #1;
                reached = (got_q.size() >= 12);
            end
            check("midrst_reach12", reached, 1);
            @(posedge CLOCK_50);
            #1;
            collect = 1'b0;
            rstn = 1'b0;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check("midrst_tx_valid", bus4.tx_valid, 0);
            check("midrst_tx_data", bus4.tx_data, 0);
            check("midrst_busy", busy4, 0);
            check("midrst_mem_rd_en", bus4.mem_rd_en, 0);
            for (int i = 0; i < 12; i++)
                if (i < got_q.size()) check($sformatf("midrst_prefix%0d", i), got_q[i], lit26[i]);
            @(posedge CLOCK_50);
            #1;
            rstn = 1'b1;
            run_vec(vecs[0], "after_rst");
        end

        // done held high through FIN, then lowered and a second dump.
        begin
            bit seen = 1'b0;
            sel = 1'b0;
            rdy_mode = 0;
            clock_count = 32'h64;
            instr_count = 32'h20;
            got_q.delete();
            rd_q.delete();
            @(posedge CLOCK_50);
            #1;
            collect = 1'b1;
            done = 1'b1;
            for (int n = 0; n < 2000 && !seen; n++) begin
                @(negedge CLOCK_50);
                seen = ddone4;
            end
            check("hold_dump_done", seen, 1);
            for (int i = 0; i < 4; i++) begin
                @(negedge CLOCK_50);
                check($sformatf("hold_done_stays%0d", i), ddone4, 1);
                check($sformatf("hold_busy_low%0d", i), busy4, 0);
            end
            @(posedge CLOCK_50);
            #1;
            done = 1'b0;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check("hold_done_clears", ddone4, 0);
            collect = 1'b0;
            build_exp(1'b1, 1'b0, 32'h64, 32'h20);
            compare_stream("hold", 26);
            wait_idle("hold");
            run_vec(vecs[0], "second");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
